prio_decoder_2to4_stream: RTL and testbench

PRIO_DECODER_2TO4_STREAM -- requirements
Module: prio_decoder_2to4_stream

---
 rtl/prio_dec_pkg.sv | 20 ++
 rtl/prio_dec_buf2.sv | 80 ++++++++
 rtl/prio_decoder_2to4_stream.sv | 71 +++++++
 tb/tb_prio_decoder_2to4_stream.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/prio_dec_pkg.sv
// Shared constants, occupancy state type and code-to-one-hot helper for the
// 2-to-4 decoder stream block.
package prio_dec_pkg;

    localparam int unsigned CODE_W   = 2;
    localparam int unsigned ONEHOT_W = 4;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned STAT_W   = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] code);
        decode = ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/prio_dec_buf2.sv
// Two-entry in-order occupancy buffer with registered handshake flags and
// look-ahead head outputs so the consumer can register its own decode.
module prio_dec_buf2
    import prio_dec_pkg::*;
#(
    parameter int unsigned DEPTH = prio_dec_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] push_code,
    input  logic              push_valid,
    output logic              push_ready,
    output logic              head_valid,
    input  logic              pop_ready,
    output logic [CODE_W-1:0] head_nxt_c,
    output logic              head_valid_nxt_c
);

    occ_state_e        state, state_nxt;
    logic [CODE_W-1:0] mem     [DEPTH];
    logic [CODE_W-1:0] mem_nxt [DEPTH];
    logic              push_c;
    logic              pop_c;

    assign push_c = push_valid && (state != TWO);
    assign pop_c  = pop_ready && (state != EMPTY);

    // State, storage and handshake flags; flags are loaded from the next state
    // so they always equal the decode of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            push_ready <= 1'b1;
            head_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            push_ready <= (state_nxt != TWO);
            head_valid <= (state_nxt != EMPTY);
            mem        <= mem_nxt;
        end
    end

    // Occupancy transitions; entry 0 is always the head.
    always_comb begin
        state_nxt = state;
        mem_nxt   = mem;
        case (state)
            EMPTY: begin
                if (push_c) begin
                    state_nxt  = ONE;
                    mem_nxt[0] = push_code;
                end
            end
            ONE: begin
                if (push_c && pop_c) begin
                    mem_nxt[0] = push_code;
                end else if (push_c) begin
                    state_nxt  = TWO;
                    mem_nxt[1] = push_code;
                end else if (pop_c) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop_c) begin
                    state_nxt  = ONE;
                    mem_nxt[0] = mem[1];
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign head_nxt_c       = mem_nxt[0];
    assign head_valid_nxt_c = (state_nxt != EMPTY);

endmodule

// File: rtl/prio_decoder_2to4_stream.sv
// Buffered 2-to-4 one-hot decoder behind a valid/ready stream.
// Optional per-code delivery counters are compiled in with DEC_STATS_EN.
module prio_decoder_2to4_stream
    import prio_dec_pkg::*;
#(
    parameter int unsigned DEPTH = prio_dec_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CODE_W-1:0]   in_code,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ONEHOT_W-1:0] out_onehot,
    output logic                out_valid,
    input  logic                out_ready
`ifdef DEC_STATS_EN
    ,
    output logic [ONEHOT_W*STAT_W-1:0] stat_cnt
`endif
);

    logic [CODE_W-1:0] head_nxt_c;
    logic              head_valid_nxt_c;

    prio_dec_buf2 #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_code        (in_code),
        .push_valid       (in_valid),
        .push_ready       (in_ready),
        .head_valid       (out_valid),
        .pop_ready        (out_ready),
        .head_nxt_c       (head_nxt_c),
        .head_valid_nxt_c (head_valid_nxt_c)
    );

    // Registered decode of the upcoming head; all-zero when nothing is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_onehot <= '0;
        end else begin
            out_onehot <= head_valid_nxt_c ? decode(head_nxt_c) : '0;
        end
    end

`ifdef DEC_STATS_EN
    logic [STAT_W-1:0] cnt_q [ONEHOT_W];

    // The registered one-hot identifies the code leaving on each pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < int'(ONEHOT_W); n++) begin
                cnt_q[n] <= '0;
            end
        end else if (out_valid && out_ready) begin
            for (int n = 0; n < int'(ONEHOT_W); n++) begin
                if (out_onehot[n] && (cnt_q[n] != {STAT_W{1'b1}})) begin
                    cnt_q[n] <= cnt_q[n] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(ONEHOT_W); g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_prio_decoder_2to4_stream.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference of a 2-entry in-order decoder stream.
module tb_prio_decoder_2to4_stream;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_onehot;
    logic       out_valid;
    logic       out_ready;
`ifdef DEC_STATS_EN
    logic [31:0] stat_cnt;
`endif

    prio_decoder_2to4_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_onehot (out_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DEC_STATS_EN
        ,
        .stat_cnt   (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] model_q [$];
    int         exp_cnt [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs derived from model occupancy and head.
    task automatic check_outputs(input string tag);
        logic [3:0] exp_oh;
        exp_oh = 4'b0000;
        if (model_q.size() > 0) exp_oh = 4'b0001 << model_q[0];
        check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
        check({tag, ".out_onehot"}, 32'(out_onehot), 32'(exp_oh));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < 2));
`ifdef DEC_STATS_EN
        check({tag, ".stat_cnt"}, stat_cnt,
              {8'(exp_cnt[3]), 8'(exp_cnt[2]), 8'(exp_cnt[1]), 8'(exp_cnt[0])});
`endif
    endtask

    // Drive one cycle from a negedge, apply the model at the posedge, check at next negedge.
    task automatic cycle(input string tag, input logic iv, input logic [1:0] c, input logic ordy);
        bit do_pop;
        bit do_push;
        in_valid  = iv;
        in_code   = c;
        out_ready = ordy;
        @(posedge clk);
        do_pop  = ordy && (model_q.size() > 0);
        do_push = iv && (model_q.size() < 2);
        if (do_pop) begin
            if (exp_cnt[model_q[0]] < 255) exp_cnt[model_q[0]]++;
            void'(model_q.pop_front());
        end
        if (do_push) model_q.push_back(c);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic pulse_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs({tag, ".released"});
    endtask

    // Behavioural 4-to-2 priority encoder: highest set bit wins.
    task automatic prio_enc(input logic [3:0] v, output logic vld, output logic [1:0] code);
        vld  = (v != 4'b0000);
        code = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) code = 2'(i);
    endtask

    logic [3:0] enc_in [5];
    logic [3:0] enc_exp [5];
    logic       ev;
    logic [1:0] ec;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'd0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        check_outputs("reset_release");

        // Single decode of code 10.
        cycle("single_push", 1'b1, 2'b10, 1'b1);
        check("single_onehot", 32'(out_onehot), 32'h4);
        cycle("single_pop", 1'b0, 2'b00, 1'b1);
        check("single_empty", 32'(out_valid), 32'h0);

        // Fill, blocked third push, then drain in order.
        cycle("full_a", 1'b1, 2'b01, 1'b0);
        cycle("full_b", 1'b1, 2'b11, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'h0);
        cycle("full_blocked", 1'b1, 2'b00, 1'b0);
        check("full_hold", 32'(out_onehot), 32'h2);
        cycle("drain_1", 1'b0, 2'b00, 1'b1);
        check("drain_1_onehot", 32'(out_onehot), 32'h8);
        cycle("drain_2", 1'b0, 2'b00, 1'b1);
        cycle("drain_3", 1'b0, 2'b00, 1'b1);

        // Simultaneous push/pop in ONE.
        cycle("sim_load", 1'b1, 2'b00, 1'b0);
        cycle("sim_swap", 1'b1, 2'b11, 1'b1);
        check("sim_onehot", 32'(out_onehot), 32'h8);
        check("sim_in_ready", 32'(in_ready), 32'h1);
        cycle("sim_drain", 1'b0, 2'b00, 1'b1);

        // Reset while holding two entries.
        cycle("rst_fill_a", 1'b1, 2'b10, 1'b0);
        cycle("rst_fill_b", 1'b1, 2'b01, 1'b0);
        pulse_reset("rst_mid_two");
        cycle("rst_after", 1'b0, 2'b00, 1'b1);

        // Encoder loopback, including the no-valid all-zero input.
        enc_in  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1110};
        enc_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            prio_enc(enc_in[i], ev, ec);
            cycle("loop_push", ev, ec, 1'b1);
            check("loop_onehot", 32'(out_onehot), 32'(enc_exp[i]));
        end
        cycle("loop_drain", 1'b0, 2'b00, 1'b1);
        prio_enc(4'b0000, ev, ec);
        cycle("loop_zero", ev, ec, 1'b1);
        check("loop_zero_valid", 32'(out_valid), 32'h0);

        // Random traffic with varied back-pressure.
        for (int i = 0; i < 1500; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            if (i == 1000) pulse_reset("rand_reset");
        end

`ifdef DEC_STATS_EN
        // Saturation of the code-01 counter.
        pulse_reset("stats_reset");
        cycle("stats_first", 1'b1, 2'b01, 1'b1);
        for (int i = 0; i < 300; i++) cycle("stats_run", 1'b1, 2'b01, 1'b1);
        check("stats_byte1", 32'(stat_cnt[15:8]), 32'd255);
        check("stats_others", 32'({stat_cnt[31:16], stat_cnt[7:0]}), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
